// File: rtl/encoder_pkg.sv
// Shared types and constants for the sequential 16-to-4 encoder.
// Holds the FSM state type, default widths and the index/mask helper.
package encoder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_IDX_W = 4;

  // Highest encodable index; bit 15 of the request vector maps here.
  localparam logic [DEFAULT_IDX_W-1:0] MAX_IDX = 4'hF;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_t;

  function automatic logic [DEFAULT_WIDTH-1:0] idx_to_mask(
    input logic [DEFAULT_IDX_W-1:0] idx
  );
    return DEFAULT_WIDTH'(1) << idx;
  endfunction

endpackage

// File: rtl/priority_encoder_16to4.sv
// Combinational lowest-set-bit finder: bit 0 has the highest priority.
// Reports index 0 with found=0 when the vector is empty.
module priority_encoder_16to4
  import encoder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDX_W = DEFAULT_IDX_W
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan from the top down so the last hit, the lowest set bit, wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = int'(MAX_IDX); i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_16to4_seq.sv
// Sequential 16-to-4 encoder: captures a request vector and emits the index
// of every set bit, lowest first, one per valid/ready handshake, then done.
module encoder_16to4_seq
  import encoder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDX_W = DEFAULT_IDX_W
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  input  logic [WIDTH-1:0] req_in,
  input  logic             load_in,
  input  logic             flush_in,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [IDX_W-1:0] idx_out,
  output logic             busy_out,
  output logic             done_out
);

  enc_state_t       state;
  enc_state_t       state_nx;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pending_nx;
  logic [WIDTH-1:0] pending_rest;
  logic             valid_nx;
  logic [IDX_W-1:0] idx_nx;
  logic             busy_nx;
  logic             done_nx;

  logic [IDX_W-1:0] load_idx;
  logic             load_found;
  logic [IDX_W-1:0] next_idx;
  logic             next_found;
  logic             handshake;

  assign handshake    = valid_out && ready_in;
  // The bit currently on idx_out is removed before looking for the next one.
  assign pending_rest = pending & ~idx_to_mask(idx_out);

  priority_encoder_16to4 #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W)
  ) u_load_enc (
    .vec  (req_in),
    .idx  (load_idx),
    .found(load_found)
  );

  priority_encoder_16to4 #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W)
  ) u_next_enc (
    .vec  (pending_rest),
    .idx  (next_idx),
    .found(next_found)
  );

  always_comb begin
    state_nx   = state;
    pending_nx = pending;
    valid_nx   = valid_out;
    idx_nx     = idx_out;
    done_nx    = 1'b0;

    if (flush_in) begin
      state_nx   = IDLE;
      pending_nx = '0;
      valid_nx   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_in) begin
            if (load_found) begin
              pending_nx = req_in;
              idx_nx     = load_idx;
              valid_nx   = 1'b1;
              state_nx   = EMIT;
            end else begin
              done_nx = 1'b1;
            end
          end
        end
        EMIT: begin
          if (handshake) begin
            pending_nx = pending_rest;
            if (next_found) begin
              idx_nx = next_idx;
            end else begin
              valid_nx = 1'b0;
              done_nx  = 1'b1;
              state_nx = IDLE;
            end
          end
        end
        default: begin
          state_nx   = IDLE;
          pending_nx = '0;
          valid_nx   = 1'b0;
        end
      endcase
    end

    busy_nx = (state_nx == EMIT);
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state     <= IDLE;
      pending   <= '0;
      valid_out <= 1'b0;
      idx_out   <= '0;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
    end else begin
      state     <= state_nx;
      pending   <= pending_nx;
      valid_out <= valid_nx;
      idx_out   <= idx_nx;
      busy_out  <= busy_nx;
      done_out  <= done_nx;
    end
  end

endmodule

// File: tb/tb_encoder_16to4_seq.sv
// Directed bench for encoder_16to4_seq: inputs driven and outputs sampled
// on the falling edge, expected values written out by hand.
module tb_encoder_16to4_seq;

  logic        clk_in;
  logic        reset_n_in;
  logic [15:0] req_in;
  logic        load_in;
  logic        flush_in;
  logic        ready_in;
  logic        valid_out;
  logic [3:0]  idx_out;
  logic        busy_out;
  logic        done_out;

  int total;
  int bad;

  encoder_16to4_seq dut (
    .clk_in    (clk_in),
    .reset_n_in(reset_n_in),
    .req_in    (req_in),
    .load_in   (load_in),
    .flush_in  (flush_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .idx_out   (idx_out),
    .busy_out  (busy_out),
    .done_out  (done_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then land on the following falling edge.
  task automatic applyStimulus();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  // Packs {valid, idx, busy, done} into one value for compact checks.
  function automatic logic [6:0] outs();
    return {valid_out, idx_out, busy_out, done_out};
  endfunction

  function automatic logic [6:0] want(input logic v, input logic [3:0] i,
                                      input logic b, input logic d);
    return {v, i, b, d};
  endfunction

  initial begin
    total      = 0;
    bad        = 0;
    reset_n_in = 1'b0;
    req_in     = '0;
    load_in    = 1'b0;
    flush_in   = 1'b0;
    ready_in   = 1'b0;

    // Reset, then an empty load
    repeat (3) applyStimulus();
    checkOutput("reset_held", 32'(outs()), 32'(want(0, 4'h0, 0, 0)));
    reset_n_in = 1'b1;
    applyStimulus();
    checkOutput("reset_released", 32'(outs()), 32'(want(0, 4'h0, 0, 0)));
    load_in = 1'b1;
    req_in  = 16'h0000;
    applyStimulus();
    load_in = 1'b0;
    checkOutput("empty_load_done", 32'(outs()), 32'(want(0, 4'h0, 0, 1)));
    applyStimulus();
    checkOutput("empty_load_after", 32'(outs()), 32'(want(0, 4'h0, 0, 0)));

    // Single bit 15
    ready_in = 1'b1;
    load_in  = 1'b1;
    req_in   = 16'h8000;
    applyStimulus();
    load_in = 1'b0;
    checkOutput("single_idx", 32'(outs()), 32'(want(1, 4'hF, 1, 0)));
    applyStimulus();
    checkOutput("single_done", {31'd0, done_out}, 32'd1);
    checkOutput("single_valid_low", {31'd0, valid_out}, 32'd0);
    checkOutput("single_busy_low", {31'd0, busy_out}, 32'd0);
    applyStimulus();
    checkOutput("single_done_pulse", {31'd0, done_out}, 32'd0);

    // Multi-bit 0A05 -> 0, 2, 9, 11
    load_in = 1'b1;
    req_in  = 16'h0A05;
    applyStimulus();
    load_in = 1'b0;
    req_in  = 16'hFFFF;
    checkOutput("multi_idx0", 32'(outs()), 32'(want(1, 4'h0, 1, 0)));
    applyStimulus();
    checkOutput("multi_idx2", 32'(outs()), 32'(want(1, 4'h2, 1, 0)));
    applyStimulus();
    checkOutput("multi_idx9", 32'(outs()), 32'(want(1, 4'h9, 1, 0)));
    applyStimulus();
    checkOutput("multi_idx11", 32'(outs()), 32'(want(1, 4'hB, 1, 0)));
    applyStimulus();
    checkOutput("multi_done", {31'd0, valid_out, busy_out, done_out}, 32'b001);

    // Backpressure on 0003 with a load pulsed during the stall
    ready_in = 1'b0;
    load_in  = 1'b1;
    req_in   = 16'h0003;
    applyStimulus();
    load_in = 1'b0;
    checkOutput("bp_stall1", 32'(outs()), 32'(want(1, 4'h0, 1, 0)));
    load_in = 1'b1;
    req_in  = 16'h8000;
    applyStimulus();
    load_in = 1'b0;
    checkOutput("bp_stall2", 32'(outs()), 32'(want(1, 4'h0, 1, 0)));
    applyStimulus();
    checkOutput("bp_stall3", 32'(outs()), 32'(want(1, 4'h0, 1, 0)));
    ready_in = 1'b1;
    applyStimulus();
    checkOutput("bp_idx1", 32'(outs()), 32'(want(1, 4'h1, 1, 0)));
    applyStimulus();
    checkOutput("bp_done", {31'd0, valid_out, busy_out, done_out}, 32'b001);
    applyStimulus();
    checkOutput("bp_no_extra", {31'd0, valid_out, busy_out, done_out}, 32'b000);

    // Flush after four accepted indices
    load_in = 1'b1;
    req_in  = 16'hFFFF;
    applyStimulus();
    load_in = 1'b0;
    checkOutput("flush_idx0", 32'(outs()), 32'(want(1, 4'h0, 1, 0)));
    repeat (3) applyStimulus();
    checkOutput("flush_idx3", 32'(outs()), 32'(want(1, 4'h3, 1, 0)));
    applyStimulus();
    checkOutput("flush_idx4", 32'(outs()), 32'(want(1, 4'h4, 1, 0)));
    flush_in = 1'b1;
    applyStimulus();
    flush_in = 1'b0;
    checkOutput("flush_idle", {31'd0, valid_out, busy_out, done_out}, 32'b000);
    applyStimulus();
    checkOutput("flush_no_done", {31'd0, valid_out, busy_out, done_out}, 32'b000);

    // Asynchronous reset mid-stream
    load_in = 1'b1;
    req_in  = 16'hFFFF;
    applyStimulus();
    load_in = 1'b0;
    applyStimulus();
    checkOutput("areset_pre", 32'(outs()), 32'(want(1, 4'h1, 1, 0)));
    #1 reset_n_in = 1'b0;
    #1;
    checkOutput("areset_async", 32'(outs()), 32'(want(0, 4'h0, 0, 0)));
    @(negedge clk_in);
    reset_n_in = 1'b1;
    applyStimulus();
    checkOutput("areset_after", 32'(outs()), 32'(want(0, 4'h0, 0, 0)));

    // Back-to-back: reload in the done cycle
    load_in = 1'b1;
    req_in  = 16'h0001;
    applyStimulus();
    load_in = 1'b0;
    checkOutput("b2b_first", 32'(outs()), 32'(want(1, 4'h0, 1, 0)));
    applyStimulus();
    checkOutput("b2b_done", {31'd0, valid_out, busy_out, done_out}, 32'b001);
    load_in = 1'b1;
    req_in  = 16'h0010;
    applyStimulus();
    load_in = 1'b0;
    checkOutput("b2b_second", 32'(outs()), 32'(want(1, 4'h4, 1, 0)));
    applyStimulus();
    checkOutput("b2b_second_done", {31'd0, valid_out, busy_out, done_out}, 32'b001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/encoder_16to4_seq.md
# encoder_16to4_seq

Sequential 16-to-4 encoder, the inverse of the one-hot decoders in this library. It captures a 16-bit request vector and emits the binary index of every set bit, lowest index first, one index per valid/ready handshake. It then pulses `done_out`. It sits between a request-collecting block and any consumer that needs binary indices, for example a `decoder_4to16` driving per-line acknowledges.

## Interface
Parameters:
- `WIDTH`, 16: request vector width. Fixed at 16 for this revision.
- `IDX_W`, 4: index width, equal to clog2(`WIDTH`).

Ports:
- `clk_in` input 1: single clock; all state changes on the rising edge.
- `reset_n_in` input 1: asynchronous, active-low reset.
- `req_in` input `WIDTH`: request vector; sampled only on an accepted load.
- `load_in` input 1: capture `req_in`; accepted only in IDLE.
- `flush_in` input 1: synchronous abort of the current vector.
- `ready_in` input 1: consumer ready for `idx_out`.
- `valid_out` output 1: `idx_out` holds a valid index.
- `idx_out` output `IDX_W`: encoded index of the lowest pending bit.
- `busy_out` output 1: high while in EMIT.
- `done_out` output 1: one-cycle pulse when a loaded vector is exhausted.

## Operation
- States: IDLE, EMIT. A `pending` register of `WIDTH` bits holds the bits not yet emitted.
- Reset values: state IDLE, `pending` 0, `valid_out` 0, `idx_out` 0, `busy_out` 0, `done_out` 0.
- IDLE with `load_in`=1 and `req_in`≠0:
  - `pending` ← `req_in`.
  - `idx_out` ← index of the lowest set bit; `valid_out` ← 1.
  - Go to EMIT.
- IDLE with `load_in`=1 and `req_in`=0: stay IDLE and pulse `done_out` next cycle. No index is emitted.
- EMIT, handshake (`valid_out`&&`ready_in`) at an edge:
  - Clear that bit in `pending`.
  - If bits remain, `idx_out` ← the next lowest set bit and `valid_out` stays 1.
  - If none remain, `valid_out` ← 0, `done_out` ← 1 for one cycle, go to IDLE.
- EMIT without a handshake: `idx_out` and `valid_out` hold. There is no skipping or reordering.
- `load_in` in EMIT is ignored; `req_in` changes in EMIT have no effect.
- `flush_in`=1 in any state:
  - Next state is IDLE, `pending` 0, `valid_out` 0.
  - No `done_out` pulse.
  - Flush wins over load and over handshake. A handshake in the flush cycle still counts as delivered to the consumer.
- Index arithmetic: find-first-set on `pending`, bit 0 has the highest priority, result in `IDX_W` bits with no wrap. Bit 15 encodes as 4'hF.
- Reset asserted mid-EMIT: all outputs go to reset values immediately (asynchronous). The vector is lost; no `done_out`.

## Timing
- Load to first valid: `valid_out` rises in the cycle after the load edge, giving 1-cycle latency.
- Throughput: with `ready_in` held high, one index per cycle. N set bits produce N consecutive valid cycles.
- `done_out` asserts in the cycle after the final handshake edge, concurrently with `busy_out` falling.
- Back-to-back vectors: a new load is accepted in the same cycle `done_out` is high, because the state is IDLE.
- All outputs are registered; there is no combinational path from `ready_in` to `valid_out` or `idx_out`.

## Structure
- Package `encoder_pkg`:
  - State enum (IDLE, EMIT).
  - `WIDTH`/`IDX_W` defaults.
  - A shared localparam for the 4'hF maximum index.
- Sub-module `priority_encoder_16to4`: combinational lowest-set-bit finder.
  - Inputs: vector `WIDTH`.
  - Outputs: `idx` `IDX_W`, `found` 1.
  - Instantiated twice: once on `req_in` for the load path, once on `pending` with the current bit masked off for the next-index path.

## Test plan
- Reset then idle: hold `reset_n_in`=0, release.
  - All outputs 0; `load_in` with 16'h0000 gives a `done_out` pulse one cycle later and no `valid_out`.
- Single bit, `ready_in`=1: load 16'h8000.
  - One valid cycle with `idx_out`=4'hF, then `done_out`.
- Multi-bit, `ready_in`=1: load 16'h0A05.
  - Indices 0, 2, 9, 11 on consecutive cycles, then `done_out`.
- Backpressure: load 16'h0003, `ready_in` low for 3 cycles then high.
  - `idx_out`=0 holds stable for 3 cycles, then 0 and 1 are accepted; a load pulsed during the stall is ignored.
- Flush and reset mid-stream: load 16'hFFFF and accept 4 indices, then `flush_in`.
  - IDLE next cycle and no `done_out`.
  - Repeat with `reset_n_in` asserted mid-stream instead: outputs clear without waiting for a clock edge.
- Back-to-back vectors: assert `load_in` with 16'h0010 in the `done_out` cycle of the previous vector.
  - `idx_out`=4 is valid on the next cycle.
